ptl: RTL and testbench
======================

# ptl

Pulse-to-level converter: the inverse of the core's level-to-pulse converter. It turns single-cycle event pulses, such as a start strobe, into a held level that stays high until the consumer acknowledges it or a timeout expires. Pulses that arrive while a level is held are counted, not lost. Queued events are replayed as separate levels, with a guaranteed low cycle between them so a downstream edge/pulse detector re-arms. It sits between strobe-producing control logic (register writes, FSM done pulses) and level-sensitive consumers in the RSA32 core.

## Interface
- CNT_W, 4: width of pending-event counter; max queued events = 2^CNT_W-1
- TIMEOUT, 0: cycles o_level may stay high without i_ack before auto-release; 0 = timeout disabled
- TMR_W, 16: timeout counter width; TIMEOUT must be < 2^TMR_W
- i_clk  input  1  clock, all state updates on rising edge
- i_rstn  input  1  asynchronous active-low reset
- i_pulse  input  1  event strobe; each high cycle is one event
- i_ack  input  1  consumer release of the currently held level
- o_level  output  1  held level, registered
- o_pending  output  CNT_W  events queued behind the one currently held, registered
- o_overflow  output  1  one-cycle flag: an event was dropped, registered
- o_timeout  output  1  one-cycle flag: level released by timeout, registered

## Operation
- Reset (i_rstn=0, async): state IDLE; o_level=0, o_pending=0, o_overflow=0, o_timeout=0; timer=0. Reset during HOLD or GAP discards the held event and all queued events.
- FSM states:
  - IDLE: o_level=0. i_pulse=1 -> HOLD; the event is taken directly and is not counted in o_pending. i_ack is ignored.
  - HOLD: o_level=1; timer increments each cycle. Release condition: i_ack=1, or (TIMEOUT!=0 and timer reaches TIMEOUT). Release -> GAP. Otherwise stay in HOLD.
  - GAP: o_level=0 for exactly 1 cycle; i_ack is ignored.
    - o_pending>0 -> HOLD, pending decremented.
    - Else i_pulse=1 -> HOLD.
    - Else -> IDLE.
- Pending counter:
  - i_pulse in HOLD: pending+1, including the release cycle.
  - i_pulse in GAP while pending>0: net pending unchanged; one event is dequeued and one is enqueued.
  - Saturation: i_pulse when pending=2^CNT_W-1 and no dequeue in the same cycle drops the event and sets o_overflow=1 for one cycle. Pending stays at max and never wraps.
- Timeout:
  - Timer clears on every entry to HOLD.
  - If i_ack=1 in the same cycle the timer reaches TIMEOUT, the ack wins and o_timeout stays 0.
  - On timeout release, o_timeout=1 for exactly the cycle after the release edge.
- o_pending is unsigned and never decrements below 0.

## Timing
- Edge numbering: "edge k" = rising edge at which an input is sampled high.
- Set latency: i_pulse sampled at edge k in IDLE -> o_level=1 after edge k; the level is visible in cycle k+1.
- Ack latency: i_ack sampled at edge m in HOLD -> o_level=0 after edge m.
- GAP length: exactly one low cycle. With a queued event, o_level is high again after edge m+1.
- Minimum level width: 1 cycle (ack sampled at the first edge after rise).
- Timeout width: o_level high for exactly TIMEOUT cycles. It falls after edge k+TIMEOUT and o_timeout is high during the cycle after that edge.
- o_pending / o_overflow update on the same edge as the sampled i_pulse.
- Back-to-back queued events: period per event = (level cycles) + 1 GAP cycle.

## Test plan
- Reset/idle: hold i_rstn=0, then release with no stimulus -> all outputs 0 for 20 cycles; i_ack pulses in IDLE have no effect.
- Single event: 1-cycle i_pulse, i_ack asserted 5 cycles after rise -> o_level high for exactly 5 cycles, then 0; o_pending stays 0.
- Queued events: i_pulse during IDLE plus 3 more during HOLD -> o_pending=3, then 3→2→1→0. Four distinct high levels result, each separated by exactly one low cycle; each release is by i_ack.
- Overflow (CNT_W=2): 1 held event plus 4 pulses during HOLD -> o_pending saturates at 3 and o_overflow pulses once on the 4th. Exactly 4 levels total.
- Timeout (TIMEOUT=8): i_pulse, no ack -> o_level high for 8 cycles and o_timeout high for 1 cycle after the fall. A repeat run with i_ack on the 8th cycle gives the same fall with o_timeout=0.
- Simultaneous/reset: i_pulse during the GAP cycle with pending=1 -> pending stays 1 and the next HOLD starts. Assert i_rstn low mid-HOLD with pending=2 -> all outputs 0 immediately, and no level replays after reset release.

Source files
------------

// File: rtl/ptl_if.sv
// ptl_if: event/level handshake bundle for the pulse-to-level converter.
//   i_pulse    - event strobe from the producer (one event per high cycle)
//   i_ack      - consumer release of the currently held level
//   o_level    - held level seen by the consumer
//   o_pending  - events queued behind the held one
//   o_overflow - one-cycle flag, an event was dropped
//   o_timeout  - one-cycle flag, level released by timeout
// The master modport is the producer/consumer side; the slave modport is ptl.
interface ptl_if #(
  parameter int CNT_W = 4
);
  logic             i_pulse;
  logic             i_ack;
  logic             o_level;
  logic [CNT_W-1:0] o_pending;
  logic             o_overflow;
  logic             o_timeout;

  modport master (
    output i_pulse, i_ack,
    input  o_level, o_pending, o_overflow, o_timeout
  );

  modport slave (
    input  i_pulse, i_ack,
    output o_level, o_pending, o_overflow, o_timeout
  );
endinterface

// File: rtl/ptl.sv
// ptl: pulse-to-level converter. Turns single-cycle event strobes into a held
// level that stays high until acknowledged or until an optional timeout.
// Events arriving while a level is held are queued in a saturating counter
// and replayed as separate levels, each followed by one low cycle so that a
// downstream edge detector re-arms.
// Ports:
//   i_clk  - clock, rising edge
//   i_rstn - asynchronous active-low reset
//   bus    - ptl_if slave modport (i_pulse, i_ack in; o_level, o_pending,
//            o_overflow, o_timeout out, all outputs registered)
// Parameters:
//   CNT_W   - pending counter width (max 2^CNT_W-1 queued events)
//   TIMEOUT - cycles the level may stay high without ack; 0 disables
//   TMR_W   - timeout counter width, TIMEOUT < 2^TMR_W
module ptl #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 0,
  parameter int TMR_W   = 16
) (
  input logic  i_clk,
  input logic  i_rstn,
  ptl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam bit               TMO_EN   = (TIMEOUT != 0);
  // Timer counts from 0 in the first HOLD cycle, so the last allowed HOLD
  // cycle is the one where it holds TIMEOUT-1.
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pend, pend_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             level_q, ovf_q, tmo_q;
  logic             ovf_nxt, tmo_nxt;
  logic             tmo_hit;

  // Saturating increment: never wraps past the maximum queue depth.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == PEND_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Decrement floored at zero.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  assign tmo_hit = TMO_EN && (timer == TMO_LAST);

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    timer_nxt = timer;
    ovf_nxt   = 1'b0;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        // Event goes straight to the level, never through the queue.
        if (bus.i_pulse) begin
          state_nxt = HOLD;
          timer_nxt = '0;
        end
      end
      HOLD: begin
        timer_nxt = timer + TMR_W'(1);
        if (bus.i_pulse) begin
          if (pend == PEND_MAX) ovf_nxt = 1'b1;
          else                  pend_nxt = sat_inc(pend);
        end
        // Ack has priority, so a same-cycle timeout is not flagged.
        if (bus.i_ack) begin
          state_nxt = GAP;
        end else if (tmo_hit) begin
          state_nxt = GAP;
          tmo_nxt   = 1'b1;
        end
      end
      GAP: begin
        if (pend != '0) begin
          // A pulse here is enqueued while one is dequeued: net unchanged.
          state_nxt = HOLD;
          timer_nxt = '0;
          if (!bus.i_pulse) pend_nxt = sat_dec(pend);
        end else if (bus.i_pulse) begin
          state_nxt = HOLD;
          timer_nxt = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= IDLE;
      pend    <= '0;
      timer   <= '0;
      level_q <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pend    <= pend_nxt;
      timer   <= timer_nxt;
      level_q <= (state_nxt == HOLD);
      ovf_q   <= ovf_nxt;
      tmo_q   <= tmo_nxt;
    end
  end

  assign bus.o_level    = level_q;
  assign bus.o_pending  = pend;
  assign bus.o_overflow = ovf_q;
  assign bus.o_timeout  = tmo_q;

endmodule

// File: tb/tb_ptl.sv
// tb_ptl: directed bench for ptl. dut_a uses CNT_W=4 with timeout disabled,
// dut_b uses CNT_W=2 with TIMEOUT=8. Outputs are sampled 1 time unit after
// each rising edge; inputs change at the same point and are sampled on the
// following edge.
module tb_ptl;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  ptl_if #(.CNT_W(4)) if_a ();
  ptl_if #(.CNT_W(2)) if_b ();

  ptl #(.CNT_W(4), .TIMEOUT(0), .TMR_W(16)) dut_a (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (if_a)
  );

  ptl #(.CNT_W(2), .TIMEOUT(8), .TMR_W(16)) dut_b (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (if_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed=%h expected=%h (level,pending,overflow,timeout)",
             tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic lvl, input logic [3:0] pend,
                       input logic ovf, input logic tmo);
    logic [6:0] obs, exp;
    obs = {if_a.o_level, if_a.o_pending, if_a.o_overflow, if_a.o_timeout};
    exp = {lvl, pend, ovf, tmo};
    chk(tag, int'(obs), int'(exp));
  endtask

  task automatic chk_b(input string tag, input logic lvl, input logic [1:0] pend,
                       input logic ovf, input logic tmo);
    logic [4:0] obs, exp;
    obs = {if_b.o_level, if_b.o_pending, if_b.o_overflow, if_b.o_timeout};
    exp = {lvl, pend, ovf, tmo};
    chk(tag, int'(obs), int'(exp));
  endtask

  initial begin
    if_a.i_pulse = 1'b0; if_a.i_ack = 1'b0;
    if_b.i_pulse = 1'b0; if_b.i_ack = 1'b0;

    // Reset and idle
    #12;
    chk_a("rst_a", 1'b0, 4'd0, 1'b0, 1'b0);
    chk_b("rst_b", 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if_a.i_ack = i[0];
      if_b.i_ack = i[1];
      tick();
      chk_a("idle_a", 1'b0, 4'd0, 1'b0, 1'b0);
      chk_b("idle_b", 1'b0, 2'd0, 1'b0, 1'b0);
    end
    if_a.i_ack = 1'b0; if_b.i_ack = 1'b0;

    // Single event, ack in the 5th high cycle
    if_a.i_pulse = 1'b1;
    tick();
    if_a.i_pulse = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk_a("single_hold", 1'b1, 4'd0, 1'b0, 1'b0);
      if (c == 5) if_a.i_ack = 1'b1;
      tick();
      if_a.i_ack = 1'b0;
    end
    chk_a("single_gap", 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk_a("single_idle", 1'b0, 4'd0, 1'b0, 1'b0);

    // Queued events: one taken, three queued, replayed 3->2->1->0
    if_a.i_pulse = 1'b1;
    tick();
    chk_a("q_take", 1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    chk_a("q_pend1", 1'b1, 4'd1, 1'b0, 1'b0);
    tick();
    chk_a("q_pend2", 1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    chk_a("q_pend3", 1'b1, 4'd3, 1'b0, 1'b0);
    if_a.i_pulse = 1'b0;
    if_a.i_ack = 1'b1;
    tick();
    if_a.i_ack = 1'b0;
    chk_a("q_gap0", 1'b0, 4'd3, 1'b0, 1'b0);
    for (int p = 2; p >= 0; p--) begin
      tick();
      chk_a("q_replay_rise", 1'b1, 4'(p), 1'b0, 1'b0);
      tick();
      chk_a("q_replay_hold", 1'b1, 4'(p), 1'b0, 1'b0);
      if_a.i_ack = 1'b1;
      tick();
      if_a.i_ack = 1'b0;
      chk_a("q_replay_gap", 1'b0, 4'(p), 1'b0, 1'b0);
    end
    tick();
    chk_a("q_idle", 1'b0, 4'd0, 1'b0, 1'b0);

    // Overflow on CNT_W=2: saturate at 3, single overflow flag
    if_b.i_pulse = 1'b1;
    tick();
    chk_b("ovf_take", 1'b1, 2'd0, 1'b0, 1'b0);
    tick();
    chk_b("ovf_p1", 1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    chk_b("ovf_p2", 1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    chk_b("ovf_p3", 1'b1, 2'd3, 1'b0, 1'b0);
    tick();
    chk_b("ovf_drop", 1'b1, 2'd3, 1'b1, 1'b0);
    if_b.i_pulse = 1'b0;
    tick();
    chk_b("ovf_clear", 1'b1, 2'd3, 1'b0, 1'b0);
    if_b.i_ack = 1'b1;
    tick();
    if_b.i_ack = 1'b0;
    chk_b("ovf_gap0", 1'b0, 2'd3, 1'b0, 1'b0);
    for (int p = 2; p >= 0; p--) begin
      tick();
      chk_b("ovf_replay_rise", 1'b1, 2'(p), 1'b0, 1'b0);
      if_b.i_ack = 1'b1;
      tick();
      if_b.i_ack = 1'b0;
      chk_b("ovf_replay_gap", 1'b0, 2'(p), 1'b0, 1'b0);
    end
    tick();
    chk_b("ovf_idle", 1'b0, 2'd0, 1'b0, 1'b0);

    // Timeout: 8 high cycles then a one-cycle timeout flag
    if_b.i_pulse = 1'b1;
    tick();
    if_b.i_pulse = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk_b("tmo_hold", 1'b1, 2'd0, 1'b0, 1'b0);
      tick();
    end
    chk_b("tmo_fall", 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    chk_b("tmo_after", 1'b0, 2'd0, 1'b0, 1'b0);

    // Ack in the 8th cycle wins over the timeout
    if_b.i_pulse = 1'b1;
    tick();
    if_b.i_pulse = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk_b("tmo_ack_hold", 1'b1, 2'd0, 1'b0, 1'b0);
      if (c == 8) if_b.i_ack = 1'b1;
      tick();
      if_b.i_ack = 1'b0;
    end
    chk_b("tmo_ack_fall", 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    chk_b("tmo_ack_idle", 1'b0, 2'd0, 1'b0, 1'b0);

    // Pulse during GAP with pending=1, then async reset mid-HOLD
    if_a.i_pulse = 1'b1;
    tick();
    tick();
    chk_a("sim_pend1", 1'b1, 4'd1, 1'b0, 1'b0);
    if_a.i_pulse = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk_a("sim_no_tmo", 1'b1, 4'd1, 1'b0, 1'b0);
    end
    if_a.i_ack = 1'b1;
    tick();
    if_a.i_ack = 1'b0;
    chk_a("sim_gap", 1'b0, 4'd1, 1'b0, 1'b0);
    if_a.i_pulse = 1'b1;
    tick();
    chk_a("sim_gap_pulse", 1'b1, 4'd1, 1'b0, 1'b0);
    tick();
    if_a.i_pulse = 1'b0;
    chk_a("sim_pend2", 1'b1, 4'd2, 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk_a("async_rst", 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    #3;
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_a("post_rst", 1'b0, 4'd0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
